// File: rtl/color_sequence_monitor.sv
// Receive-side checker for the RGB colour-cycling LED drive: glitch-filters the
// three lines, decodes a colour, measures each colour's dwell and flags order/timing faults.
module color_sequence_monitor #(
    parameter int COLOR_INTERVAL = 2000000,
    parameter int TOLERANCE      = 16,
    parameter int STABLE_CYCLES  = 4,
    localparam int DW            = $clog2(COLOR_INTERVAL + TOLERANCE + 1) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          red,
    input  logic          green,
    input  logic          blue,
    output logic [2:0]    color,
    output logic          color_valid,
    output logic [DW-1:0] dwell,
    output logic          locked,
    output logic          seq_err,
    output logic          dwell_err,
    output logic          illegal_err,
    output logic [7:0]    err_count,
    output logic [1:0]    dbg_state
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
    localparam logic [DW-1:0] HI_LIM   = DW'(COLOR_INTERVAL + TOLERANCE);
    localparam logic [DW-1:0] LO_LIM   =
        DW'((COLOR_INTERVAL > TOLERANCE) ? (COLOR_INTERVAL - TOLERANCE) : 0);

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        FIRST   = 2'd1,
        TRACK   = 2'd2
    } state_t;

    state_t        r_state;
    logic [2:0]    r_in_q;
    logic [2:0]    r_prev;
    logic [2:0]    r_acc_raw;
    logic          r_acc_vld;
    logic [SW-1:0] r_stab;
    logic [DW-1:0] r_dwell_cnt;
    logic [DW-1:0] r_dwell;
    logic [2:0]    r_color;
    logic          r_valid;
    logic          r_locked;
    logic          r_seq_err;
    logic          r_dwell_err;
    logic          r_ill_err;
    logic [7:0]    r_err_count;

    logic [2:0]    w_cand;
    logic          w_legal;
    logic [SW-1:0] w_stab_next;
    logic          w_accept;
    logic [2:0]    w_succ;
    logic [DW-1:0] w_meas;
    logic          w_dwell_bad;
    logic          w_timeout;

    function automatic logic [2:0] decode(input logic [2:0] rgb);
        case (rgb)
            3'b100:  return 3'd0;
            3'b110:  return 3'd1;
            3'b010:  return 3'd2;
            3'b011:  return 3'd3;
            3'b001:  return 3'd4;
            3'b101:  return 3'd5;
            default: return 3'd7;
        endcase
    endfunction

    // Stability is tracked on the raw code so OFF followed by WHITE is still a new acceptance.
    always_comb begin
        w_cand  = decode(r_in_q);
        w_legal = (w_cand != 3'd7);
        if (r_in_q != r_prev)
            w_stab_next = SW'(1);
        else if (r_stab >= STAB_MAX)
            w_stab_next = STAB_MAX;
        else
            w_stab_next = r_stab + SW'(1);
        w_accept    = (w_stab_next == STAB_MAX) && (!r_acc_vld || (r_in_q != r_acc_raw));
        w_succ      = (r_color >= 3'd5) ? 3'd0 : (r_color + 3'd1);
        w_meas      = (r_dwell_cnt == '1) ? r_dwell_cnt : (r_dwell_cnt + DW'(1));
        w_dwell_bad = (w_meas > HI_LIM) || (w_meas < LO_LIM);
        w_timeout   = (r_state == TRACK) && !w_accept && (r_dwell_cnt == HI_LIM);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ACQUIRE;
            r_in_q      <= 3'd0;
            r_prev      <= 3'd0;
            r_acc_raw   <= 3'd0;
            r_acc_vld   <= 1'b0;
            r_stab      <= '0;
            r_dwell_cnt <= '0;
            r_dwell     <= '0;
            r_color     <= 3'd7;
            r_valid     <= 1'b0;
            r_locked    <= 1'b0;
            r_seq_err   <= 1'b0;
            r_dwell_err <= 1'b0;
            r_ill_err   <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_in_q      <= {red, green, blue};
            r_prev      <= r_in_q;
            r_stab      <= w_stab_next;
            r_dwell_cnt <= w_accept ? '0 : w_meas;
            r_valid     <= 1'b0;
            r_seq_err   <= 1'b0;
            r_dwell_err <= 1'b0;
            r_ill_err   <= 1'b0;

            if (w_accept) begin
                r_valid   <= 1'b1;
                r_color   <= w_cand;
                r_acc_raw <= r_in_q;
                r_acc_vld <= 1'b1;
                r_dwell   <= w_meas;
                case (r_state)
                    ACQUIRE: begin
                        if (!w_legal) r_ill_err <= 1'b1;
                        else          r_state   <= FIRST;
                    end
                    FIRST: begin
                        if (!w_legal) begin
                            r_ill_err <= 1'b1;
                            r_state   <= ACQUIRE;
                        end else if (w_cand == w_succ) begin
                            r_state  <= TRACK;
                            r_locked <= 1'b1;
                        end else begin
                            r_seq_err <= 1'b1;
                        end
                    end
                    TRACK: begin
                        if (!w_legal) begin
                            r_ill_err <= 1'b1;
                            r_locked  <= 1'b0;
                            r_state   <= ACQUIRE;
                        end else if (w_cand == w_succ) begin
                            r_dwell_err <= w_dwell_bad;
                        end else begin
                            r_seq_err <= 1'b1;
                            r_locked  <= 1'b0;
                            r_state   <= FIRST;
                        end
                    end
                    default: begin
                        r_locked <= 1'b0;
                        r_state  <= ACQUIRE;
                    end
                endcase
            end else if (w_timeout) begin
                // Colour frozen past the upper bound: report once, then re-acquire.
                r_dwell_err <= 1'b1;
                r_locked    <= 1'b0;
                r_state     <= ACQUIRE;
            end

            if ((r_seq_err || r_dwell_err || r_ill_err) && (r_err_count != 8'hFF))
                r_err_count <= r_err_count + 8'd1;
        end
    end

    assign color       = r_color;
    assign color_valid = r_valid;
    assign dwell       = r_dwell;
    assign locked      = r_locked;
    assign seq_err     = r_seq_err;
    assign dwell_err   = r_dwell_err;
    assign illegal_err = r_ill_err;
    assign err_count   = r_err_count;
    assign dbg_state   = r_state;

endmodule
